data_memory: RTL and testbench

- Word-addressed single-port data RAM for the soft processor's load/store path; 4096 x 32 by default.
- Synchronous write, registered read with one-cycle latency.
- Adds a hardware clear sequencer: after reset it zeroes every word, then raises ready.
- Sits between the processor's dmem port (address/data/wren/q) and nothing else; one clock domain.

---
 rtl/data_memory_pkg.sv | 12 +
 rtl/dmem_array.sv | 32 +++
 rtl/data_memory.sv | 75 +++++++
 tb/tb_data_memory.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared constants and sweep state type for the data memory and its array.
package data_memory_pkg;

    localparam int DMEM_ADDR_WIDTH = 12;
    localparam int DMEM_DATA_WIDTH = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port RAM: synchronous write, registered read, write-through on the same edge.
module dmem_array
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // The array itself has no reset so it still maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wren)
            mem[address] <= data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= '0;
        else if (rden)
            q <= wren ? data : mem[address];
    end

endmodule

// File: rtl/data_memory.sv
// Data RAM for the load/store path, with a zero-fill sweep after reset.
//
//   state | meaning
//   CLEAR | writing zero to sweep_addr each edge; ready low, user access blocked
//   RUN   | sweep done (or disabled); ready rises on the next edge and stays up
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH     = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DMEM_DATA_WIDTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  ready
);

    localparam sweep_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    sweep_state_t          state;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  sweeping;
    logic                  mem_wren;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RESET_STATE;
            sweep_addr <= '0;
            ready      <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ready      <= 1'b0;
                    sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
                    if (sweep_addr == '1)
                        state <= RUN;
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= RESET_STATE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates the write so the held CLEAR state cannot zero address 0 early.
    assign sweeping = (state == CLEAR);
    assign mem_wren = !reset && (sweeping || (ready && wren));
    assign mem_addr = sweeping ? sweep_addr : address;
    assign mem_data = sweeping ? '0 : data;

    // Reads are gated by ready, so q holds its reset value of 0 through the sweep.
    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .address (mem_addr),
        .data    (mem_data),
        .wren    (mem_wren),
        .rden    (ready),
        .q       (q)
    );

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: clear sweep, latency, write-through, mid-sweep reset, retention.
module tb_data_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic        reset_nc;
    logic [11:0] address;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;
    logic        ready;
    logic [31:0] q_nc;
    logic        ready_nc;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    data_memory #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .CLEAR_ON_RESET(1)) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q),
        .ready   (ready)
    );

    data_memory #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .CLEAR_ON_RESET(0)) dut_nc (
        .clock   (clock),
        .reset   (reset_nc),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q_nc),
        .ready   (ready_nc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic w);
        address = a;
        data    = d;
        wren    = w;
    endtask

    // Counts edges after the current point until ready is seen high (bounded).
    task automatic edges_to_ready(output int n);
        n = 0;
        while (n < 5000) begin
            step();
            n++;
            if (ready) break;
        end
    endtask

    int n;

    initial begin
        reset    = 1'b1;
        reset_nc = 1'b1;
        drive(12'd0, 32'd0, 1'b0);
        repeat (3) step();
        check("rst_q", q, 32'h0);
        check("rst_ready", {31'b0, ready}, 32'd1 - 32'd1);

        // Sweep with a user write held on address 10 throughout; it must be dropped.
        drive(12'd10, 32'hAAAA5555, 1'b1);
        reset = 1'b0;
        n = 0;
        while (n < 5000) begin
            step();
            n++;
            if (n == 100) check("sweep_q_held", q, 32'h0);
            if (ready) break;
        end
        check("sweep_edges", n, 32'd4097);

        drive(12'd0, 32'd0, 1'b0);
        step();
        check("clr_rd0", q, 32'h0);
        drive(12'd1234, 32'd0, 1'b0);
        step();
        check("clr_rd1234", q, 32'h0);
        drive(12'd4095, 32'd0, 1'b0);
        step();
        check("clr_rd4095", q, 32'h0);
        drive(12'd10, 32'd0, 1'b0);
        step();
        check("blocked_wr10", q, 32'h0);

        // Latency: old q stays until the edge that samples the new address.
        drive(12'd5, 32'hDEADBEEF, 1'b1);
        step();
        drive(12'd0, 32'd0, 1'b0);
        step();
        check("lat_pre_rd0", q, 32'h0);
        drive(12'd5, 32'd0, 1'b0);
        #2;
        check("lat_before_edge", q, 32'h0);
        step();
        check("lat_rd5", q, 32'hDEADBEEF);

        drive(12'd7, 32'h12345678, 1'b1);
        step();
        check("wthru_7", q, 32'h12345678);
        drive(12'd4095, 32'hFFFFFFFF, 1'b1);
        step();
        check("wthru_4095", q, 32'hFFFFFFFF);
        drive(12'd0, 32'h00000001, 1'b1);
        step();
        check("wthru_0", q, 32'h00000001);
        drive(12'd4095, 32'd0, 1'b0);
        step();
        check("rd_4095", q, 32'hFFFFFFFF);
        drive(12'd0, 32'd0, 1'b0);
        step();
        check("rd_0", q, 32'h00000001);
        drive(12'd7, 32'd0, 1'b0);
        step();
        check("rd_7", q, 32'h12345678);
        drive(12'd5, 32'd0, 1'b0);
        step();
        check("rd_5", q, 32'hDEADBEEF);

        // Async reset while running with nonzero q.
        #2;
        reset = 1'b1;
        #1;
        check("async_q_run", q, 32'h0);
        check("async_ready_run", {31'b0, ready}, 32'h0);
        step();
        #2;
        reset = 1'b0;
        repeat (2000) step();
        check("mid_sweep_ready", {31'b0, ready}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("async_q_sweep", q, 32'h0);
        check("async_ready_sweep", {31'b0, ready}, 32'h0);
        step();
        #2;
        reset = 1'b0;
        #2;
        edges_to_ready(n);
        check("restart_edges", n, 32'd4097);
        drive(12'd5, 32'd0, 1'b0);
        step();
        check("recleared_5", q, 32'h0);
        drive(12'd4095, 32'd0, 1'b0);
        step();
        check("recleared_4095", q, 32'h0);

        // Retention with no sweep.
        reset_nc = 1'b0;
        #1;
        check("nc_ready_pre", {31'b0, ready_nc}, 32'h0);
        step();
        check("nc_ready_1edge", {31'b0, ready_nc}, 32'h1);
        drive(12'd100, 32'h0BADF00D, 1'b1);
        step();
        drive(12'd100, 32'd0, 1'b0);
        step();
        check("nc_rd100", q_nc, 32'h0BADF00D);
        reset_nc = 1'b1;
        #1;
        check("nc_async_q", q_nc, 32'h0);
        repeat (3) step();
        reset_nc = 1'b0;
        #1;
        check("nc_ready_pre2", {31'b0, ready_nc}, 32'h0);
        step();
        check("nc_ready_1edge2", {31'b0, ready_nc}, 32'h1);
        step();
        check("nc_retained_100", q_nc, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
